ibis_texel_fetch: RTL and testbench
===================================

Name: ibis_texel_fetch

Overview:
Downstream neighbour of the texture mapper. Accepts one texture-tile address plus stencil result per mapped pixel, issues a read to the synchronous tile RAM, and returns the texel in order on a valid/ready stream to the pixel writer. Stencil-failed pixels bypass the RAM and emit a border texel flagged transparent. Credit-based back-pressure lets the pixel pipeline stall the mapper via its enable.

Parameters:
TILE_SIZE_POW2, 7, log2 of tile edge; address width is 2*TILE_SIZE_POW2.
TEXEL_WIDTH, 16, bits per texel.
RAM_LATENCY, 1, tile RAM read latency in cycles, legal 1..3.
FIFO_DEPTH_POW2, 2, log2 of output FIFO depth (default 4 entries).
BORDER_TEXEL, 0, texel value emitted for stencil-failed pixels.

Ports:
aclk  in  1  clock.
areset  in  1  synchronous active-high reset.
in_valid  in  1  mapper result valid (driven from mapper ready & enable).
in_ready  out  1  block can take a result; drives mapper enable.
in_address  in  2*TILE_SIZE_POW2  tile address {v,u}.
in_stencil  in  1  1 = pixel inside tile.
tex_rd_en  out  1  tile RAM read strobe.
tex_rd_addr  out  2*TILE_SIZE_POW2  tile RAM read address.
tex_rd_data  in  TEXEL_WIDTH  tile RAM data, valid RAM_LATENCY cycles after strobe.
chroma_key  in  TEXEL_WIDTH  transparent colour (used only with optional feature).
out_valid  out  1  texel available.
out_ready  in  1  consumer accepts texel.
out_texel  out  TEXEL_WIDTH  texel value.
out_transparent  out  1  texel to be skipped by writer.

Behaviour:
- Clock aclk; reset areset synchronous active-high. During/after reset: out_valid=0, out_texel=0, out_transparent=0, tex_rd_en=0, tex_rd_addr=0, in_ready=1 from first cycle after reset release, FIFO empty, in-flight count 0.
- Accept on edge where in_valid & in_ready. Issue stage registered: in cycle after accept, tex_rd_en=in_stencil, tex_rd_addr=in_address; stencil-fail gives tex_rd_en=0, tex_rd_addr holds previous value.
- Shift register of RAM_LATENCY+1 {valid,stencil} tags tracks in-flight entries; when a valid tag reaches the end, FIFO is written with {tex_rd_data,0} if stencil else {BORDER_TEXEL,1}.
- Latency: accept at edge N -> out_valid high in cycle N+2+RAM_LATENCY with FIFO empty (3 cycles default).
- Ordering strict: output order equals accept order, stencil fail or not.
- Credit: in_ready = (fifo_count + inflight_count) < 2**FIFO_DEPTH_POW2, combinational from registered counts only (no in_valid/out_ready path). Simultaneous accept and pop: counts net correctly; in_ready does not reflect the pop until next cycle.
- FIFO pop on out_valid & out_ready; out_texel/out_transparent from FIFO head, stable while out_valid & !out_ready.
- Full: in_ready=0, no data lost since credits cover in-flight reads. Empty: out_valid=0, out_texel holds last value.
- Reset mid-operation: in-flight tags and FIFO discarded; late RAM data ignored.

Optional Feature:
IBIS_TEXEL_FETCH_CHROMA_KEY_EN: defined -> fetched texel equal to chroma_key is written with transparent=1 (texel value kept). Undefined -> chroma_key port present but ignored; transparent set only by stencil fail.

Decomposition:
- Package ibis_texel_pkg: texel_t (logic [TEXEL_WIDTH-1:0]), fifo entry struct {texel_t texel; logic transparent;}, RAM_LATENCY_MAX=3.
- Sub-module ibis_sync_fifo: parameterised synchronous FIFO (push/pop/count/full/empty, areset flush), reused elsewhere.

Test Plan:
- Reset: areset high 2 cycles -> out_valid=0, tex_rd_en=0, in_ready=1 next cycle.
- Single hit: in_address=14'h0105, stencil=1, RAM returns 16'hBEEF -> tex_rd_addr=14'h0105 cycle N+1, out_valid cycle N+3, out_texel=16'hBEEF, transparent=0.
- Mixed order: hit A(16'h1111), miss, hit B(16'h2222) back-to-back -> outputs 1111/0, 0000/1, 2222/0 in order; no tex_rd_en for miss.
- Back-pressure: out_ready=0, stream continuously -> exactly 4 accepts then in_ready=0; release out_ready -> 4 texels in order, in_ready returns, no loss/duplication.
- Simultaneous push/pop at full-minus-one over 100 random cycles -> scoreboard match, counts never exceed 4.
- Chroma (macro defined): chroma_key=16'hF81F, RAM returns F81F -> out_transparent=1; macro undefined -> 0.

Source files
------------

// File: rtl/ibis_texel_fetch_pkg.sv
// Shared types for the texel fetch path: texel word, FIFO entry, latency bound.
package ibis_texel_pkg;
  localparam int TEXEL_W         = 16;
  localparam int RAM_LATENCY_MAX = 3;

  typedef logic [TEXEL_W-1:0] texel_t;

  typedef struct packed {
    texel_t texel;
    logic   transparent;
  } fifo_entry_t;
endpackage

// File: rtl/ibis_texel_fetch_if.sv
// Mapper-side, tile-RAM-side and pixel-writer-side signals of the texel fetch block.
interface ibis_texel_fetch_if #(
  parameter int AW = 14,
  parameter int TW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_address;
  logic          in_stencil;
  logic          tex_rd_en;
  logic [AW-1:0] tex_rd_addr;
  logic [TW-1:0] tex_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_texel;
  logic          out_transparent;

  modport slave (
    input  in_valid, in_address, in_stencil, tex_rd_data, out_ready,
    output in_ready, tex_rd_en, tex_rd_addr, out_valid, out_texel, out_transparent
  );

  modport master (
    output in_valid, in_address, in_stencil, tex_rd_data, out_ready,
    input  in_ready, tex_rd_en, tex_rd_addr, out_valid, out_texel, out_transparent
  );
endinterface

// File: rtl/ibis_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; reset flushes pointers (storage is not cleared).
module ibis_sync_fifo #(
  parameter int WIDTH      = 17,
  parameter int DEPTH_POW2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_POW2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_POW2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_POW2:0] wr_ptr, rd_ptr;

  // Extra pointer MSB distinguishes full from empty.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (DEPTH_POW2+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr[DEPTH_POW2-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[DEPTH_POW2-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ibis_texel_fetch.sv
// Texel fetch: issues tile RAM reads, tags in-flight pixels, returns texels in order
// with credit back-pressure. Optional IBIS_TEXEL_FETCH_CHROMA_KEY_EN marks chroma-key hits transparent.
module ibis_texel_fetch
  import ibis_texel_pkg::*;
#(
  parameter int TILE_SIZE_POW2  = 7,
  parameter int TEXEL_WIDTH     = 16,
  parameter int RAM_LATENCY     = 1,
  parameter int FIFO_DEPTH_POW2 = 2,
  parameter logic [TEXEL_WIDTH-1:0] BORDER_TEXEL = '0
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [TEXEL_WIDTH-1:0] chroma_key,
  ibis_texel_fetch_if.slave      bus
);
  localparam int LAT   = (RAM_LATENCY < 1) ? 1 :
                         (RAM_LATENCY > RAM_LATENCY_MAX) ? RAM_LATENCY_MAX : RAM_LATENCY;
  localparam int AW    = 2 * TILE_SIZE_POW2;
  localparam int EW    = TEXEL_WIDTH + 1;
  localparam int CW    = FIFO_DEPTH_POW2 + 2;
  localparam int DEPTH = 1 << FIFO_DEPTH_POW2;

  logic                     accept, wr, wr_stencil, key_hit, pop;
  logic [LAT:0]             vld_pipe, stn_pipe;
  logic [CW-1:0]            inflight;
  logic [EW-1:0]            wr_entry, head, last;
  logic [FIFO_DEPTH_POW2:0] fifo_count;
  logic                     fifo_full, fifo_empty;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;

  // Credit from registered counts only, so in_ready never depends on in_valid/out_ready.
  assign bus.in_ready = ({1'b0, fifo_count} + inflight) < CW'(DEPTH);
  assign accept       = bus.in_valid & bus.in_ready;

  assign wr         = vld_pipe[LAT];
  assign wr_stencil = stn_pipe[LAT];

`ifdef IBIS_TEXEL_FETCH_CHROMA_KEY_EN
  assign key_hit = (bus.tex_rd_data == chroma_key);
`else
  logic unused_chroma;
  assign unused_chroma = ^chroma_key;
  assign key_hit       = 1'b0;
`endif

  assign wr_entry = wr_stencil ? {bus.tex_rd_data, key_hit} : {BORDER_TEXEL, 1'b1};

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      vld_pipe <= '0;
      stn_pipe <= '0;
      inflight <= '0;
      last     <= '0;
    end else begin
      rd_en <= accept & bus.in_stencil;
      if (accept && bus.in_stencil) rd_addr <= bus.in_address;
      vld_pipe <= {vld_pipe[LAT-1:0], accept};
      stn_pipe <= {stn_pipe[LAT-1:0], bus.in_stencil};
      inflight <= inflight + CW'(accept) - CW'(wr);
      if (pop) last <= head;
    end
  end

  assign bus.tex_rd_en   = rd_en;
  assign bus.tex_rd_addr = rd_addr;

  ibis_sync_fifo #(
    .WIDTH      (EW),
    .DEPTH_POW2 (FIFO_DEPTH_POW2)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (wr),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Once drained, the last popped texel stays on the output.
  assign pop                 = bus.out_valid & bus.out_ready;
  assign bus.out_valid       = ~fifo_empty;
  assign bus.out_texel       = fifo_empty ? last[EW-1:1] : head[EW-1:1];
  assign bus.out_transparent = fifo_empty ? last[0]      : head[0];

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_ibis_texel_fetch.sv
// Scoreboard bench for ibis_texel_fetch with a 1-cycle synchronous tile RAM model.
module tb_ibis_texel_fetch;
  import ibis_texel_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] chroma_key;

  ibis_texel_fetch_if #(.AW(14), .TW(16)) bus ();

  ibis_texel_fetch #(
    .TILE_SIZE_POW2 (7),
    .TEXEL_WIDTH    (16),
    .RAM_LATENCY    (1),
    .FIFO_DEPTH_POW2(2),
    .BORDER_TEXEL   (16'h0000)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .chroma_key (chroma_key),
    .bus        (bus)
  );

  always #5 aclk = ~aclk;

  logic [15:0] mem [16384];
  logic [15:0] ram_q;
  always @(posedge aclk) if (bus.tex_rd_en) ram_q <= mem[bus.tex_rd_addr];
  assign bus.tex_rd_data = ram_q;

  fifo_entry_t sb[$];
  fifo_entry_t e;
  int n_checks = 0;
  int n_fail   = 0;

`ifdef IBIS_TEXEL_FETCH_CHROMA_KEY_EN
  localparam logic CHROMA_EXP = 1'b1;
`else
  localparam logic CHROMA_EXP = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every beat popped by the DUT must match the scoreboard head.
  always @(negedge aclk) begin
    if (!areset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("out_texel", {16'h0, bus.out_texel}, {16'h0, e.texel});
        check("out_transparent", {31'h0, bus.out_transparent}, {31'h0, e.transparent});
      end
    end
  end

  task automatic send(input logic [13:0] a, input logic s, input logic [15:0] et, input logic ett);
    int t = 0;
    logic r;
    bus.in_valid   = 1'b1;
    bus.in_address = a;
    bus.in_stencil = s;
    forever begin
      @(negedge aclk);
      r = bus.in_ready;
      @(posedge aclk);
      if (r) begin
        sb.push_back('{texel: et, transparent: ett});
        break;
      end
      t++;
      if (t > 50) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    #1;
  endtask

  task automatic drain();
    int t = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge aclk); #1;
      t++;
    end
    check("drain_done", sb.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = {2'b10, 14'(i)};
    mem[14'h0105] = 16'hBEEF;
    mem[14'h0110] = 16'h1111;
    mem[14'h0112] = 16'h2222;
    for (int i = 0; i < 4; i++) mem[14'h0200 + i] = 16'hA000 + 16'(i);
    mem[14'h0300] = 16'hF81F;

    areset         = 1'b1;
    chroma_key     = 16'hF81F;
    bus.in_valid   = 1'b0;
    bus.in_address = '0;
    bus.in_stencil = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    @(negedge aclk);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_rd_en", {31'h0, bus.tex_rd_en}, 32'd0);
    check("rst_rd_addr", {18'h0, bus.tex_rd_addr}, 32'd0);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("rst_out_texel", {16'h0, bus.out_texel}, 32'd0);
    check("rst_out_transparent", {31'h0, bus.out_transparent}, 32'd0);
    @(posedge aclk); #1;

    // Single hit: read address the cycle after accept, texel two cycles later.
    send(14'h0105, 1'b1, 16'hBEEF, 1'b0);
    bus.in_valid = 1'b0;
    check("hit_rd_en", {31'h0, bus.tex_rd_en}, 32'd1);
    check("hit_rd_addr", {18'h0, bus.tex_rd_addr}, 32'h0105);
    @(negedge aclk);
    check("lat_n1_out_valid", {31'h0, bus.out_valid}, 32'd0);
    @(negedge aclk);
    check("lat_n2_out_valid", {31'h0, bus.out_valid}, 32'd0);
    @(negedge aclk);
    check("lat_n3_out_valid", {31'h0, bus.out_valid}, 32'd1);
    @(posedge aclk); #1;
    drain();
    @(negedge aclk);
    check("empty_hold_texel", {16'h0, bus.out_texel}, 32'h0000BEEF);
    check("empty_out_valid", {31'h0, bus.out_valid}, 32'd0);
    @(posedge aclk); #1;

    // Mixed hit/miss/hit back-to-back.
    send(14'h0110, 1'b1, 16'h1111, 1'b0);
    check("mix_a_rd_en", {31'h0, bus.tex_rd_en}, 32'd1);
    send(14'h0111, 1'b0, 16'h0000, 1'b1);
    check("mix_miss_rd_en", {31'h0, bus.tex_rd_en}, 32'd0);
    check("mix_miss_rd_addr", {18'h0, bus.tex_rd_addr}, 32'h0110);
    send(14'h0112, 1'b1, 16'h2222, 1'b0);
    check("mix_b_rd_en", {31'h0, bus.tex_rd_en}, 32'd1);
    check("mix_b_rd_addr", {18'h0, bus.tex_rd_addr}, 32'h0112);
    drain();

    // Back-pressure: consumer stalled, exactly four credits.
    begin
      int k = 0;
      logic r;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
        bus.in_valid   = 1'b1;
        bus.in_address = 14'h0200 + 14'(k);
        bus.in_stencil = 1'b1;
        @(negedge aclk);
        r = bus.in_ready;
        @(posedge aclk);
        if (r) begin
          sb.push_back('{texel: 16'hA000 + 16'(k), transparent: 1'b0});
          k++;
        end
        #1;
      end
      bus.in_valid = 1'b0;
      @(negedge aclk);
      check("bp_accepts", k, 32'd4);
      check("bp_in_ready_low", {31'h0, bus.in_ready}, 32'd0);
      check("bp_stall_texel", {16'h0, bus.out_texel}, 32'h0000A000);
      check("bp_stall_valid", {31'h0, bus.out_valid}, 32'd1);
      @(posedge aclk); #1;
      bus.out_ready = 1'b1;
      drain();
      @(negedge aclk);
      check("bp_in_ready_back", {31'h0, bus.in_ready}, 32'd1);
      @(posedge aclk); #1;
    end

    // Random push/pop near full.
    begin
      logic r;
      logic [13:0] a;
      logic s;
      for (int c = 0; c < 100; c++) begin
        a              = 14'h1000 + 14'($urandom_range(0, 4095));
        s              = 1'($urandom_range(0, 1));
        bus.in_valid   = ($urandom_range(0, 3) != 0);
        bus.in_address = a;
        bus.in_stencil = s;
        bus.out_ready  = ($urandom_range(0, 3) != 0);
        @(negedge aclk);
        r = bus.in_valid & bus.in_ready;
        check("occupancy_le4", {31'h0, (sb.size() <= 4)}, 32'd1);
        @(posedge aclk);
        if (r) sb.push_back(s ? '{texel: mem[a], transparent: 1'b0}
                              : '{texel: 16'h0000, transparent: 1'b1});
        #1;
      end
      bus.out_ready = 1'b1;
      drain();
    end

    // Reset mid-operation discards in-flight work.
    send(14'h0110, 1'b1, 16'h1111, 1'b0);
    send(14'h0112, 1'b1, 16'h2222, 1'b0);
    bus.in_valid = 1'b0;
    areset = 1'b1;
    sb.delete();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      check("post_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    end
    check("post_rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check("post_rst_out_texel", {16'h0, bus.out_texel}, 32'd0);
    @(posedge aclk); #1;

    // Chroma-key texel.
    send(14'h0300, 1'b1, 16'hF81F, CHROMA_EXP);
    drain();

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
